// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one block-wide data memory between an instruction cache (read only)
//   and a data cache (read/write). One transaction runs at a time through
//   IDLE -> ISSUE -> WAIT -> DONE. The requester that was granted sees its
//   busywait drop for the single DONE cycle.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : simultaneous requests alternate, starting with the D cache
//     undefined : simultaneous requests always go to the D cache
//
// Ports
//   clock, reset                 clock; asynchronous active-high reset
//   i_read, i_address            instruction-cache read request and address
//   i_readdata, i_busywait       block returned to I cache; I-cache stall
//   d_read, d_write, d_address,  data-cache request, address and write block
//   d_writedata
//   d_readdata, d_busywait       block returned to D cache; D-cache stall
//   mem_read, mem_write,         registered strobes, address and write block
//   mem_address, mem_writedata   towards the shared memory
//   mem_readdata, mem_busywait   block and busy flag from the shared memory
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_read,
    input  logic [27:0]  i_address,
    output logic [127:0] i_readdata,
    output logic         i_busywait,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [27:0]  d_address,
    input  logic [127:0] d_writedata,
    output logic [127:0] d_readdata,
    output logic         d_busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    logic   grant;      // 0 = data cache, 1 = instruction cache
    logic   d_req;
    logic   pick_i;     // requester chosen if a grant is issued this cycle

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;   // grant of the most recently completed transaction

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        pick_i = ~d_req;
        if (d_req && i_read)
            pick_i = ~last_grant;
    end
`else
    always_comb begin
        pick_i = ~d_req;
    end
`endif

    // Busywait is combinational so the requester sees it drop in DONE itself;
    // reset is folded in so both stalls read 0 the moment reset rises.
    assign i_busywait = ~reset & i_read & ~((state == DONE) &  grant);
    assign d_busywait = ~reset & d_req  & ~((state == DONE) & ~grant);

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge, independent of order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b1;   // so the data cache wins the first tie
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (d_req || i_read) begin
                        grant <= pick_i;
                        state <= ISSUE;
                        if (pick_i) begin
                            mem_address <= i_address;
                            mem_read    <= 1'b1;
                            mem_write   <= 1'b0;
                        end else begin
                            // read+write together is served as a write only
                            mem_address   <= d_address;
                            mem_writedata <= d_writedata;
                            mem_write     <= d_write;
                            mem_read      <= ~d_write;
                        end
                    end
                end
                // memory may not have raised busywait yet, so ISSUE never
                // looks at it
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (!mem_busywait) begin
                        if (mem_read) begin
                            if (grant) i_readdata <= mem_readdata;
                            else       d_readdata <= mem_readdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed and randomized bench for mem_arbiter. Two cache agents each work
//   through a queue of transactions, holding their request until served. A
//   reference model derives the service order and returned data from the
//   arbitration rules; a simple memory model answers with variable latency.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         i_read;
    logic [27:0]  i_address;
    logic [127:0] i_readdata;
    logic         i_busywait;
    logic         d_read;
    logic         d_write;
    logic [27:0]  d_address;
    logic [127:0] d_writedata;
    logic [127:0] d_readdata;
    logic         d_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address),
        .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_readdata(d_readdata),
        .d_busywait(d_busywait),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic         is_d;
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } txn_t;

    txn_t dq[$];
    txn_t iq[$];
    txn_t order[$];
    bit   served[$];              // 1 = D served, 0 = I served, in order

    logic [127:0] env_mem [logic [27:0]];
    logic [127:0] ref_mem [logic [27:0]];

    int compared   = 0;
    int mismatched = 0;
    int cyc;
    int wr_pulses;
    int first_done_cyc;
    int lat_fixed;
    int cnt;
    int issue_idx;
    int done_idx;
    bit active;
    bit model_last_i;
    logic [127:0] model_i_rd;
    logic [127:0] model_d_rd;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dflt(input logic [27:0] a);
        return {4{a, 4'h5}};
    endfunction

    function automatic logic [127:0] env_rd(input logic [27:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [127:0] ref_rd(input logic [27:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    // Service order when both agents keep re-requesting: ties go to D, or
    // with alternation to the side opposite the last completed grant.
    task automatic build_order();
        txn_t q_d[$] = dq;
        txn_t q_i[$] = iq;
        bit   take_i;
        order.delete();
        while (q_d.size() != 0 || q_i.size() != 0) begin
            if (q_d.size() != 0 && q_i.size() != 0)
                take_i = RR ? !model_last_i : 1'b0;
            else
                take_i = (q_i.size() != 0);
            order.push_back(take_i ? q_i.pop_front() : q_d.pop_front());
            model_last_i = take_i;
        end
    endtask

    task automatic drive_agents();
        if (dq.size() != 0) begin
            d_read      = dq[0].rd;
            d_write     = dq[0].wr;
            d_address   = dq[0].addr;
            d_writedata = dq[0].data;
        end else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        if (iq.size() != 0) begin
            i_read    = 1'b1;
            i_address = iq[0].addr;
        end else begin
            i_read = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_mem_read"},      128'(mem_read),      '0);
        check({pfx, "_mem_write"},     128'(mem_write),     '0);
        check({pfx, "_i_busywait"},    128'(i_busywait),    '0);
        check({pfx, "_d_busywait"},    128'(d_busywait),    '0);
        check({pfx, "_mem_address"},   128'(mem_address),   '0);
        check({pfx, "_mem_writedata"}, mem_writedata,       '0);
        check({pfx, "_i_readdata"},    i_readdata,          '0);
        check({pfx, "_d_readdata"},    d_readdata,          '0);
    endtask

    task automatic reset_env();
        model_last_i = 1'b1;
        model_i_rd   = '0;
        model_d_rd   = '0;
        active       = 1'b0;
        mem_busywait = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        reset_env();
    endtask

    // Memory: busy for cnt WAIT cycles, then returns/accepts the block.
    task automatic mem_model();
        txn_t e;
        if ((mem_read || mem_write) && !active) begin
            active       = 1'b1;
            cnt          = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            mem_busywait = 1'b1;
            mem_readdata = {4{$urandom}};
            if (mem_write) wr_pulses++;
            if (issue_idx < order.size()) begin
                e = order[issue_idx];
                check("issue_mem_read",  128'(mem_read),  128'(e.rd && !e.wr));
                check("issue_mem_write", 128'(mem_write), 128'(e.wr));
                check("issue_address",   128'(mem_address), 128'(e.addr));
                if (e.wr) check("issue_writedata", mem_writedata, e.data);
            end
            issue_idx++;
        end else if (active && (mem_read || mem_write)) begin
            if (cnt == 0) begin
                mem_busywait = 1'b0;
                if (mem_write) env_mem[mem_address] = mem_writedata;
                else           mem_readdata = env_rd(mem_address);
            end else begin
                cnt--;
            end
        end else if (!(mem_read || mem_write)) begin
            active       = 1'b0;
            mem_busywait = 1'b0;
        end
    endtask

    task automatic completions();
        txn_t e;
        bit i_done = i_read && !i_busywait;
        bit d_done = (d_read || d_write) && !d_busywait;
        if (!(d_read || d_write)) check("d_busy_idle", 128'(d_busywait), '0);
        if (!i_read)              check("i_busy_idle", 128'(i_busywait), '0);
        if (i_done || d_done) begin
            e = order[done_idx];
            check("who_served", 128'({d_done, i_done}), 128'({e.is_d, !e.is_d}));
            if (e.wr)        ref_mem[e.addr] = e.data;
            else if (e.is_d) model_d_rd = ref_rd(e.addr);
            else             model_i_rd = ref_rd(e.addr);
            check("i_readdata", i_readdata, model_i_rd);
            check("d_readdata", d_readdata, model_d_rd);
            if (first_done_cyc < 0) first_done_cyc = cyc;
            served.push_back(d_done);
            done_idx++;
            if (i_done && iq.size() != 0) void'(iq.pop_front());
            if (d_done && dq.size() != 0) void'(dq.pop_front());
            drive_agents();
        end
    endtask

    // Runs both agent queues to completion; rst_at > 0 pulses reset in that cycle.
    task automatic run(input int rst_at);
        build_order();
        issue_idx = 0;
        done_idx = 0;
        first_done_cyc = -1;
        cyc = 0;
        served.delete();
        drive_agents();
        while (done_idx < order.size()) begin
            step();
            if (cyc > 4000) begin
                check("run_timeout", 128'(done_idx), 128'(order.size()));
                break;
            end
            if (cyc == rst_at) begin
                reset = 1'b1;
                #1;
                check_all_zero("midrst");
                reset_env();
                issue_idx = done_idx;
                @(posedge clock);
                #1;
                reset = 1'b0;
                continue;
            end
            mem_model();
            completions();
        end
    endtask

    initial begin : main
        bit exp20 [4];
        txn_t t;
        int nd, ni, ty;

        reset = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
        mem_readdata = '0; mem_busywait = 1'b0;
        wr_pulses = 0;
        lat_fixed = 0;
        reset_env();
        #2;
        check_all_zero("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // I-cache read, memory busy for 5 cycles
        env_mem[28'h10] = {16{8'hA5}};
        ref_mem[28'h10] = {16{8'hA5}};
        iq.push_back('{1'b0, 1'b1, 1'b0, 28'h0000010, 128'h0});
        lat_fixed = 5;
        run(-1);
        check("i_latency", 128'(first_done_cyc), 128'(8));
        check("i_readdata_a5", i_readdata, {16{8'hA5}});
        step();
        check("i_busy_after", 128'(i_busywait), '0);

        // D-cache write: one pulse, d_readdata untouched
        wr_pulses = 0;
        lat_fixed = 2;
        dq.push_back('{1'b1, 1'b0, 1'b1, 28'h0000003,
                       128'h00112233445566778899AABBCCDDEEFF});
        run(-1);
        check("wr_pulses", 128'(wr_pulses), 128'(1));
        check("wr_mem", env_rd(28'h3), 128'h00112233445566778899AABBCCDDEEFF);
        check("wr_d_readdata_hold", d_readdata, '0);

        // read+write together behaves as a write
        wr_pulses = 0;
        dq.push_back('{1'b1, 1'b1, 1'b1, 28'h0000004, {4{32'hCAFE0004}}});
        run(-1);
        check("rw_pulses", 128'(wr_pulses), 128'(1));
        check("rw_mem", env_rd(28'h4), {4{32'hCAFE0004}});

        // simultaneous reads, two per side: D goes first
        do_reset();
        lat_fixed = 1;
        for (int k = 0; k < 2; k++) begin
            dq.push_back('{1'b1, 1'b1, 1'b0, 28'(8 + k), 128'h0});
            iq.push_back('{1'b0, 1'b1, 1'b0, 28'(12 + k), 128'h0});
        end
        run(-1);
        check("tie_first_d", 128'(served.size() > 0 && served[0]), 128'(1));
        check("tie_last_i", 128'(served.size() == 4 && !served[3]), 128'(1));

        // four per side continuously re-requesting
        do_reset();
        lat_fixed = 0;
        for (int k = 0; k < 4; k++) begin
            dq.push_back('{1'b1, 1'b1, 1'b0, 28'(k), 128'h0});
            iq.push_back('{1'b0, 1'b1, 1'b0, 28'(16 + k), 128'h0});
        end
        if (RR) exp20 = '{1'b1, 1'b0, 1'b1, 1'b0};
        else    exp20 = '{1'b1, 1'b1, 1'b1, 1'b1};
        run(-1);
        for (int k = 0; k < 4; k++)
            check($sformatf("order4_%0d", k),
                  128'(served.size() > k ? served[k] : 1'bx), 128'(exp20[k]));

        // reset during WAIT of an I read, held request completes afterwards
        do_reset();
        lat_fixed = 10;
        iq.push_back('{1'b0, 1'b1, 1'b0, 28'h0000020, 128'h0});
        run(4);
        check("post_rst_i_readdata", i_readdata, dflt(28'h20));

        // randomized rounds
        lat_fixed = -1;
        for (int r = 0; r < 10; r++) begin
            nd = int'($urandom_range(0, 4));
            ni = int'($urandom_range(0, 4));
            if (nd == 0 && ni == 0) ni = 1;
            for (int k = 0; k < nd; k++) begin
                ty = int'($urandom_range(0, 2));
                t.is_d = 1'b1;
                t.rd   = (ty != 1);
                t.wr   = (ty != 0);
                t.addr = 28'($urandom_range(0, 7));
                t.data = {$urandom, $urandom, $urandom, $urandom};
                dq.push_back(t);
            end
            for (int k = 0; k < ni; k++)
                iq.push_back('{1'b0, 1'b1, 1'b0, 28'($urandom_range(0, 7)), 128'h0});
            run(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
